// File: rtl/bus_master_arbiter_pkg.sv
// Shared types for the CPU-side bus master arbiter and the bus CDC block.
package bus_master_arbiter_pkg;

    localparam int address_width = 32;
    localparam int data_width    = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        CAPTURE,
        ABORT,
        PARK
    } arb_state_t;

    typedef struct packed {
        logic                     we;
        logic [3:0]               we_ram;
        logic [address_width-1:0] address;
        logic [data_width-1:0]    data;
    } bus_req_t;

endpackage

// File: rtl/bus_master_arbiter_if.sv
// Requester-side and bus-side signals of the arbiter, bundled for port hookup.
// Handshake: a master raises req_i with stable we/addr/wdata and holds it until
// done_o for that master pulses; err_o and rdata_o are meaningful in that cycle.
interface bus_master_arbiter_if
    import bus_master_arbiter_pkg::*;
#(
    parameter int NumMasters = 2,
    parameter int AddrWidth  = address_width,
    parameter int DataWidth  = data_width
);
    logic [NumMasters-1:0]                req_i;
    logic [NumMasters-1:0]                we_i;
    logic [NumMasters-1:0][3:0]           we_ram_i;
    logic [NumMasters-1:0][AddrWidth-1:0] addr_i;
    logic [NumMasters-1:0][DataWidth-1:0] wdata_i;
    logic [NumMasters-1:0]                gnt_o;
    logic [NumMasters-1:0]                done_o;
    logic                                 err_o;
    logic [DataWidth-1:0]                 rdata_o;
    logic                                 bus_we_o;
    logic [3:0]                           bus_we_ram_o;
    logic [AddrWidth-1:0]                 bus_address_o;
    logic [DataWidth-1:0]                 bus_data_o;
    logic [DataWidth-1:0]                 bus_data_i;
    logic                                 bus_busy_i;

    modport master (
        input  req_i, we_i, we_ram_i, addr_i, wdata_i, bus_data_i, bus_busy_i,
        output gnt_o, done_o, err_o, rdata_o,
               bus_we_o, bus_we_ram_o, bus_address_o, bus_data_o
    );

    modport slave (
        output req_i, we_i, we_ram_i, addr_i, wdata_i, bus_data_i, bus_busy_i,
        input  gnt_o, done_o, err_o, rdata_o,
               bus_we_o, bus_we_ram_o, bus_address_o, bus_data_o
    );
endinterface

// File: rtl/bus_master_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module bus_master_arbiter_rr_arbiter #(
    parameter  int NumMasters = 2,
    localparam int PtrWidth   = (NumMasters > 1) ? $clog2(NumMasters) : 1
) (
    input  logic [NumMasters-1:0] req,
    input  logic [PtrWidth-1:0]   ptr,
    output logic [NumMasters-1:0] gnt,
    output logic [PtrWidth-1:0]   gnt_idx,
    output logic                  found
);
    logic [PtrWidth-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < NumMasters; i++) begin
            idx = PtrWidth'((int'(ptr) + i) % NumMasters);
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end
endmodule

// File: rtl/bus_master_arbiter.sv
// Shares the CPU-side bus master port between NumMasters requesters, sequencing
// each access through issue, CDC busy wait, capture and a parking cycle.
module bus_master_arbiter
    import bus_master_arbiter_pkg::*;
#(
    parameter int                   NumMasters     = 2,
    parameter int                   AddrWidth      = address_width,
    parameter int                   DataWidth      = data_width,
    parameter logic [AddrWidth-1:0] IdleAddress    = '1,
    parameter int                   BusyWaitCycles = 2,
    parameter int                   TimeoutCycles  = 1024
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    bus_master_arbiter_if.master arb,
    output arb_state_t           state_o
);
    localparam int CntWidth = $clog2(TimeoutCycles) + 1;
    localparam int PtrWidth = (NumMasters > 1) ? $clog2(NumMasters) : 1;
    localparam bus_req_t BusIdle = '{we: 1'b0, we_ram: 4'h0, address: IdleAddress, data: '0};

    // The bus request struct is shared with the CDC, so widths are tied to the package.
    if (AddrWidth != address_width || DataWidth != data_width) begin : g_width_check
        $error("bus_master_arbiter: AddrWidth/DataWidth must match the package widths");
    end

    arb_state_t            state;
    logic [CntWidth-1:0]   cnt;
    logic [PtrWidth-1:0]   rr_ptr;
    logic [PtrWidth-1:0]   g_idx;
    logic [NumMasters-1:0] gnt;
    logic [NumMasters-1:0] done;
    logic                  err;
    logic [DataWidth-1:0]  rdata;
    bus_req_t              bus;

    logic [NumMasters-1:0] pick_gnt;
    logic [PtrWidth-1:0]   pick_idx;
    logic                  pick_found;

    bus_master_arbiter_rr_arbiter #(.NumMasters(NumMasters)) u_rr (
        .req     (arb.req_i),
        .ptr     (rr_ptr),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .found   (pick_found)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state  <= IDLE;
            cnt    <= '0;
            rr_ptr <= '0;
            g_idx  <= '0;
            gnt    <= '0;
            done   <= '0;
            err    <= 1'b0;
            rdata  <= '0;
            bus    <= BusIdle;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt         <= pick_gnt;
                        g_idx       <= pick_idx;
                        bus.we      <= arb.we_i[pick_idx];
                        bus.we_ram  <= arb.we_ram_i[pick_idx];
                        bus.address <= arb.addr_i[pick_idx];
                        bus.data    <= arb.wdata_i[pick_idx];
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                // No busy within the window means the target lives in this clock domain.
                WAIT_BUSY: begin
                    if (arb.bus_busy_i) begin
                        cnt   <= '0;
                        state <= WAIT_DONE;
                    end else if (cnt == CntWidth'(BusyWaitCycles - 1)) begin
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!arb.bus_busy_i) begin
                        state <= CAPTURE;
                    end else if (cnt == CntWidth'(TimeoutCycles - 1)) begin
                        state <= ABORT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    rdata <= arb.bus_data_i;
                    done  <= gnt;
                    err   <= 1'b0;
                    bus   <= BusIdle;
                    state <= PARK;
                end
                ABORT: begin
                    rdata <= '0;
                    done  <= gnt;
                    err   <= 1'b1;
                    bus   <= BusIdle;
                    state <= PARK;
                end
                // Parking guarantees an idle-address cycle so repeated addresses look new downstream.
                PARK: begin
                    done   <= '0;
                    err    <= 1'b0;
                    gnt    <= '0;
                    rr_ptr <= (g_idx == PtrWidth'(NumMasters - 1)) ? '0 : g_idx + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign arb.gnt_o         = gnt;
    assign arb.done_o        = done;
    assign arb.err_o         = err;
    assign arb.rdata_o       = rdata;
    assign arb.bus_we_o      = bus.we;
    assign arb.bus_we_ram_o  = bus.we_ram;
    assign arb.bus_address_o = bus.address;
    assign arb.bus_data_o    = bus.data;
    assign state_o           = state;
endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed scoreboard bench for bus_master_arbiter with a simple CDC busy responder.
module tb_bus_master_arbiter;
    import bus_master_arbiter_pkg::*;

    localparam int NM = 2;
    localparam int AW = address_width;
    localparam int DW = data_width;
    localparam int TO = 16;
    localparam int BW = 2;
    localparam logic [AW-1:0] IDLE_A = '1;

    typedef struct packed {
        logic          m;
        logic          e;
        logic [DW-1:0] rd;
        logic [7:0]    lat;
        logic          we;
        logic [3:0]    wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    arb_state_t state_dbg;
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int busy_len = 0;

    bus_master_arbiter_if #(.NumMasters(NM)) arb_if ();

    bus_master_arbiter #(
        .NumMasters     (NM),
        .BusyWaitCycles (BW),
        .TimeoutCycles  (TO)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .arb       (arb_if.master),
        .state_o   (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic m, input logic e, input logic [DW-1:0] rd,
                                        input int lat, input logic we, input logic [3:0] wr,
                                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t x;
        x = '{m: m, e: e, rd: rd, lat: 8'(lat), we: we, wr: wr, a: a, d: d};
        return W'(x);
    endfunction

    // driver tasks
    task automatic issue(input logic m, input logic we, input logic [3:0] wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        arb_if.we_i[m]     = we;
        arb_if.we_ram_i[m] = wr;
        arb_if.addr_i[m]   = a;
        arb_if.wdata_i[m]  = d;
        arb_if.req_i[m]    = 1'b1;
    endtask

    task automatic wait_done(input logic m);
        int  t;
        bit  got;
        t   = 0;
        got = 1'b0;
        while (!got && t < 200) begin
            @(negedge clk);
            got = arb_if.done_o[m];
            t++;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_done_m%0d: no done_o after %0d cycles, required a pulse", m, t);
        end
        arb_if.req_i[m] = 1'b0;
    endtask

    // CDC responder: raises busy from the issue cycle for busy_len cycles, drops on idle address
    int   rem = 0;
    logic r_prev_idle = 1'b1;
    always @(negedge clk) begin
        if (!rst_n || arb_if.bus_address_o == IDLE_A) begin
            rem = 0;
            arb_if.bus_busy_i = 1'b0;
        end else begin
            if (r_prev_idle) rem = busy_len;
            arb_if.bus_busy_i = (rem > 0);
            if (rem > 0) rem--;
        end
        r_prev_idle = !rst_n || (arb_if.bus_address_o == IDLE_A);
    end

    // scoreboard monitor
    logic          prev_idle = 1'b1;
    logic          in_txn = 1'b0;
    int            lat = 0;
    logic [AW-1:0] iss_a;
    logic [DW-1:0] iss_d;
    logic          iss_we;
    logic [3:0]    iss_wr;
    exp_t          e;
    logic [NM-1:0] oh;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_idle = 1'b1;
            in_txn    = 1'b0;
        end else begin
            if (in_txn) lat++;
            if (arb_if.bus_address_o != IDLE_A && prev_idle) begin
                in_txn = 1'b1;
                lat    = 0;
                iss_a  = arb_if.bus_address_o;
                iss_d  = arb_if.bus_data_o;
                iss_we = arb_if.bus_we_o;
                iss_wr = arb_if.bus_we_ram_o;
            end
            if (arb_if.done_o != '0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: done_o=%b, required no pulse", arb_if.done_o);
                end else begin
                    e  = exp_t'(exp_q.pop_front());
                    oh = NM'(1) << e.m;
                    check("done_o",      arb_if.done_o, oh);
                    check("gnt_o",       arb_if.gnt_o, oh);
                    check("err_o",       arb_if.err_o, e.e);
                    check("rdata_o",     arb_if.rdata_o, e.rd);
                    check("latency",     lat, e.lat);
                    check("park_addr",   arb_if.bus_address_o, IDLE_A);
                    check("park_we",     arb_if.bus_we_o, 1'b0);
                    check("issue_addr",  iss_a, e.a);
                    check("issue_we",    iss_we, e.we);
                    check("issue_we_ram", iss_wr, e.wr);
                    check("issue_data",  iss_d, e.d);
                    in_txn = 1'b0;
                end
            end
            prev_idle = (arb_if.bus_address_o == IDLE_A);
        end
    end

    task automatic check_reset_values();
        check("rst_gnt",    arb_if.gnt_o, '0);
        check("rst_done",   arb_if.done_o, '0);
        check("rst_err",    arb_if.err_o, 1'b0);
        check("rst_rdata",  arb_if.rdata_o, '0);
        check("rst_addr",   arb_if.bus_address_o, IDLE_A);
        check("rst_we",     arb_if.bus_we_o, 1'b0);
        check("rst_we_ram", arb_if.bus_we_ram_o, 4'h0);
        check("rst_data",   arb_if.bus_data_o, '0);
        check("rst_state",  state_dbg, IDLE);
    endtask

    // stimulus
    initial begin
        arb_if.req_i      = '0;
        arb_if.we_i       = '0;
        arb_if.we_ram_i   = '0;
        arb_if.addr_i     = '0;
        arb_if.wdata_i    = '0;
        arb_if.bus_data_i = '0;
        arb_if.bus_busy_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // master 0 write, busy for 5 cycles: 7 cycles of address, then park
        busy_len = 5;
        arb_if.bus_data_i = 32'h0000_0011;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h11, 7, 1'b1, 4'hF, 32'h9000, 32'h1234));
        issue(1'b0, 1'b1, 4'hF, 32'h9000, 32'h1234);
        wait_done(1'b0);
        @(negedge clk);
        check("rdata_held", arb_if.rdata_o, 32'h11);
        check("gnt_cleared", arb_if.gnt_o, '0);

        // master 1 read, bypass (no busy): done 2+BW cycles after issue
        busy_len = 0;
        arb_if.bus_data_i = 32'h0000_CAFE;
        exp_q.push_back(mk(1'b1, 1'b0, 32'hCAFE, 2 + BW, 1'b0, 4'h0, 32'h9008, 32'h0));
        issue(1'b1, 1'b0, 4'h0, 32'h9008, 32'h0);
        wait_done(1'b1);

        // both masters, same address: grants alternate 0,1,0,1
        arb_if.bus_data_i = 32'h0000_5555;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h5555, 4, 1'b0, 4'h0, 32'h9004, 32'h0));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h5555, 4, 1'b1, 4'h3, 32'h9004, 32'hB1));
        exp_q.push_back(mk(1'b0, 1'b0, 32'h5555, 4, 1'b0, 4'h0, 32'h9004, 32'h0));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h5555, 4, 1'b1, 4'h3, 32'h9004, 32'hB1));
        issue(1'b0, 1'b0, 4'h0, 32'h9004, 32'h0);
        issue(1'b1, 1'b1, 4'h3, 32'h9004, 32'hB1);
        wait_done(1'b0);
        issue(1'b0, 1'b0, 4'h0, 32'h9004, 32'h0);
        wait_done(1'b1);
        issue(1'b1, 1'b1, 4'h3, 32'h9004, 32'hB1);
        wait_done(1'b0);
        wait_done(1'b1);

        // busy stuck high: abort after TO WAIT_DONE cycles (1+1+TO+1 to done)
        busy_len = 1000;
        arb_if.bus_data_i = 32'h0000_7777;
        exp_q.push_back(mk(1'b0, 1'b1, 32'h0, 3 + TO, 1'b1, 4'hF, 32'h9010, 32'hDEAD));
        issue(1'b0, 1'b1, 4'hF, 32'h9010, 32'hDEAD);
        wait_done(1'b0);

        // next request served normally
        busy_len = 0;
        arb_if.bus_data_i = 32'h0000_5A5A;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h5A5A, 4, 1'b0, 4'h0, 32'h9014, 32'h0));
        issue(1'b0, 1'b0, 4'h0, 32'h9014, 32'h0);
        wait_done(1'b0);

        // reset while master 1 sits in WAIT_DONE: no done, restart from master 0
        busy_len = 1000;
        issue(1'b1, 1'b0, 4'h0, 32'h9018, 32'h0);
        repeat (6) @(negedge clk);
        check("pre_reset_state", state_dbg, WAIT_DONE);
        #2;
        rst_n = 1'b0;
        issue(1'b0, 1'b1, 4'hF, 32'h901C, 32'h2468);
        #1;
        check_reset_values();
        busy_len = 0;
        arb_if.bus_data_i = 32'h0000_1357;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h1357, 4, 1'b1, 4'hF, 32'h901C, 32'h2468));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h1357, 4, 1'b0, 4'h0, 32'h9018, 32'h0));
        wait_done(1'b0);
        wait_done(1'b1);

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_master_arbiter.md
Name: bus_master_arbiter

Overview:
- Shares the single CPU-side bus master port (address/data/we/we_ram) between NumMasters requesters, e.g. the CPU core and a UART debug bridge, in front of the bus CDC block.
- Sequences each access: issue for one cycle, wait on the CDC busy, capture read data, then return the address to a parking value so that back-to-back same-address accesses are still detected downstream.
- Round-robin fairness, a busy-timeout watchdog and per-requester completion signalling.

Parameters:
- NumMasters, 2, number of requesters (2..8).
- AddrWidth, address_width (package), bus address width.
- DataWidth, data_width (package), bus data width.
- IdleAddress, '1, parking address driven between transactions; must map to no peripheral.
- BusyWaitCycles, 2, cycles after issue to wait for busy_i to rise before treating the access as same-domain.
- TimeoutCycles, 1024, maximum cycles busy_i may stay high before abort.

Ports:
- clk_i  in  1  CPU-domain clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- req_i  in  NumMasters  request per master; held until done_o for that master.
- we_i  in  NumMasters  write enable per master.
- we_ram_i  in  NumMasters x 4  byte write enables per master.
- addr_i  in  NumMasters x AddrWidth  address per master.
- wdata_i  in  NumMasters x DataWidth  write data per master.
- gnt_o  out  NumMasters  one-hot grant, held from ISSUE through DONE.
- done_o  out  NumMasters  one-cycle completion pulse to the granted master.
- err_o  out  1  qualifies done_o: 1 means timeout abort.
- rdata_o  out  DataWidth  read data; valid in the done_o cycle, then held.
- bus_we_o  out  1  to bus.
- bus_we_ram_o  out  4  to bus.
- bus_address_o  out  AddrWidth  to bus.
- bus_data_o  out  DataWidth  to bus.
- bus_data_i  in  DataWidth  OR-reduced read data from bus.
- bus_busy_i  in  1  busy from bus CDC.

Behaviour:
- Reset (async assert, sync release): state=IDLE; gnt_o, done_o, err_o = 0; rdata_o = 0; bus_address_o = IdleAddress; bus_we_o, bus_we_ram_o, bus_data_o = 0; rr pointer = 0.
- IDLE:
  - If any req_i is set, pick the first requesting index at or after the rr pointer (wrapping modulo NumMasters).
  - Register its gnt and its we/we_ram/addr/wdata; go to ISSUE.
  - Decision is registered; no combinational req-to-bus path.
- ISSUE (1 cycle):
  - Drive the registered bus signals; start cnt=0; go to WAIT_BUSY.
- WAIT_BUSY:
  - Bus signals held.
  - If bus_busy_i=1, go to WAIT_DONE with cnt=0.
  - Else if cnt==BusyWaitCycles-1, go to CAPTURE (bypass/same-domain access).
  - Else cnt++.
- WAIT_DONE:
  - Bus signals held.
  - If bus_busy_i=0, go to CAPTURE.
  - Else if cnt==TimeoutCycles-1, go to ABORT.
  - Else cnt++.
- CAPTURE (1 cycle):
  - rdata_o <= bus_data_i, captured for writes too; done_o[g]=1; err_o=0.
  - Bus returns to idle: address=IdleAddress, we=0, we_ram=0, data=0.
  - Go to PARK.
- ABORT (1 cycle):
  - rdata_o <= '0; done_o[g]=1; err_o=1; bus returned to idle; go to PARK.
- PARK (1 cycle):
  - gnt_o cleared; rr pointer = g+1 mod NumMasters; go to IDLE.
  - Guarantees at least one cycle of IdleAddress between any two accesses.
- Minimum latency for a same-domain access is 2+BusyWaitCycles cycles from the ISSUE entry to done_o (ISSUE + BusyWaitCycles cycles in WAIT_BUSY + CAPTURE).
- A req_i drop while granted is ignored; the transaction runs to completion. A new req from the same master is honoured only after PARK.
- Simultaneous requests are resolved by rr only; a master that was just served is lowest priority next round.
- Counter width: $clog2(TimeoutCycles)+1; no wrap.
- Reset mid-transaction: immediate return to reset values; no done_o pulse.

Decomposition:
- Package: arb_state_t enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CAPTURE, ABORT, PARK); bus_req_t packed struct (we, we_ram, address, data), reused by bus CDC.
- Sub-module: rr_arbiter (req vector + pointer -> one-hot grant, combinational) instantiated once.

Test Plan:
- Single master 0 write: addr 0x9000, data 0x1234; busy high 5 cycles -> bus shows addr 0x9000 for 7 cycles, then IdleAddress; done_o[0] one pulse, err_o=0.
- Master 1 read, no busy (bypass): bus_data_i=0xCAFE -> done_o[1] 4 cycles after the ISSUE entry (2+BusyWaitCycles with the default BusyWaitCycles=2), rdata_o=0xCAFE.
- Both masters request continuously, same address 0x9004 -> grants alternate 0,1,0,1; IdleAddress appears between every pair; four done pulses.
- busy_i stuck high, TimeoutCycles=16 -> done_o with err_o=1 after 16 WAIT_DONE cycles; rdata_o=0; next request is served normally.
- reset_n_i asserted in WAIT_DONE -> all outputs at reset values the same cycle; no done_o; after release, a pending req_i is served from master 0.
